ll_head_table_lookup: RTL and testbench
=======================================

# ll_head_table_lookup

Upstream stage of the linked-list data-table engines (enqueue and dequeue). It owns the per-queue head-pointer table and accepts one command at a time. For each command it reads the head entry of the addressed queue and presents a task (command, head pointer, head-valid flag) to the downstream engine. It then holds off further commands until the engine reports completion, which keeps each queue's head read-modify-write atomic. After reset it sweeps the table clean before accepting work.

## Interface
Parameters:
- RAM_LATENCY, 2, read latency of the head storage in cycles (≥1).
- A_WIDTH, LL_TABLE_ADDR_WIDTH, width of a data-table pointer.
- QUEUE_CNT, 16, number of queues (power of two).
- Q_WIDTH, $clog2(QUEUE_CNT), width of a queue index.

Ports:
- clk_i  in  1  clock; the block has one clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- cmd_i  in  ll_ht_command_t  command (key, opcode).
- cmd_queue_i  in  Q_WIDTH  target queue index.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid && ready.
- task_o  out  ll_ht_pdata_t  cmd, head_ptr, head_ptr_val.
- task_queue_o  out  Q_WIDTH  queue index of the task.
- task_valid_o  out  1  task valid.
- task_ready_i  in  1  engine accepts task.
- op_done_i  in  1  one-cycle pulse: the engine finished the current task (result handshake done).
- head_wr_queue_i  in  Q_WIDTH  head update: queue index.
- head_wr_ptr_i  in  A_WIDTH  head update: new pointer.
- head_wr_ptr_val_i  in  1  head update: new valid flag.
- head_wr_en_i  in  1  head update strobe.
- init_done_o  out  1  high once the clear sweep is complete.

## Operation
- State machine: CLEAR_S, IDLE_S, READ_S, OUT_S, WAIT_DONE_S.
- **CLEAR_S** (entered on reset):
  - Writes {ptr=0, val=0} to entry 0..QUEUE_CNT-1, one entry per cycle.
  - Moves to IDLE_S after the last entry; sets init_done_o.
  - head_wr_en_i is ignored in this state.
- **IDLE_S**: cmd_ready_o=1. On valid && ready, latch cmd_i and cmd_queue_i, issue the read of that entry, go to READ_S.
- **READ_S**: count RAM_LATENCY cycles. On the final cycle, latch the read data, go to OUT_S.
- **OUT_S**:
  - task_valid_o=1. task_o and task_queue_o hold the latched values and stay stable until task_ready_i.
  - On handshake, go to WAIT_DONE_S.
- **WAIT_DONE_S**: on op_done_i, go to IDLE_S.
- op_done_i arriving in any state other than WAIT_DONE_S is ignored.
- Head updates:
  - Accepted in every state except CLEAR_S.
  - Committed at the clock edge where head_wr_en_i is high.
  - A later write to the same queue overwrites the earlier one.
- Forwarding: if head_wr_en_i targets the locked queue during READ_S, or in the cycle the read is issued, the forwarded write values replace the RAM data. The freshest write wins.
- head_ptr_val=0 is passed through unchanged. The downstream engine decides how to handle an empty queue.

## Timing
- Reset values:
  - state=CLEAR_S, clear index 0.
  - cmd_ready_o=0, task_valid_o=0, init_done_o=0.
  - task_o='0, task_queue_o=0.
- Reset is asynchronous. Asserting rst_n_i mid-operation drops any in-flight task immediately and restarts the clear sweep.
- Clear sweep: init_done_o and cmd_ready_o rise exactly QUEUE_CNT cycles after reset release.
- Lookup latency: acceptance at edge T gives task_valid_o=1 in the cycle after edge T+RAM_LATENCY+1, i.e. RAM_LATENCY+1 cycles.
- Throughput: at most one command outstanding. The next cmd_ready_o rises the cycle after op_done_i is sampled.
- Simultaneous op_done_i and head_wr_en_i on the same edge are both honoured. The write is visible to the next lookup.
- task_valid_o never drops without task_ready_i.

## Test plan
- **Clear:** release reset, hold cmd_valid_i=1 → cmd_ready_o=0 for 16 cycles then 1. A lookup of queue 5 returns head_ptr_val=0, head_ptr=0.
- **Write then read:**
  - Write queue 3 = {0x2A, 1}. Lookup queue 3 → task_o.head_ptr=0x2A, head_ptr_val=1, task_queue_o=3.
  - task_valid_o is high exactly 3 cycles after acceptance (RAM_LATENCY=2).
- **Forwarding:** accept a lookup of queue 7 (stored {0x10,1}). Write {0x11,1} to queue 7 on the next cycle → task shows 0x11.
- **Serialization:**
  - After the task handshake, cmd_ready_o stays 0 with op_done_i held low for 20 cycles.
  - Pulse op_done_i together with a write of queue 7 = {0,0} → cmd_ready_o=1 the next cycle. A relookup of queue 7 gives val=0.
- **Backpressure:** hold task_ready_i=0 for 10 cycles → task_o stable and task_valid_o high throughout. A stray op_done_i in OUT_S is ignored.
- **Reset mid-task:** assert rst_n_i=0 during READ_S → task_valid_o=0 and cmd_ready_o=0 at once. After release, a new 16-cycle sweep leaves all entries invalid.

Source files
------------

// File: rtl/ll_head_table_pkg.sv
// Shared command/task types for the linked-list data-table engines.
package ll_head_table_pkg;

    localparam int LL_TABLE_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        LL_OP_ENQ  = 2'd0,
        LL_OP_DEQ  = 2'd1,
        LL_OP_PEEK = 2'd2,
        LL_OP_NOP  = 2'd3
    } ll_op_e;

    typedef struct packed {
        logic [7:0] key;
        ll_op_e     opcode;
    } ll_ht_command_t;

    typedef struct packed {
        ll_ht_command_t                 cmd;
        logic [LL_TABLE_ADDR_WIDTH-1:0] head_ptr;
        logic                           head_ptr_val;
    } ll_ht_pdata_t;

endpackage

// File: rtl/ll_head_table_lookup.sv
// Per-queue head-pointer table: one locked lookup at a time, released by op_done_i.
// A_WIDTH must equal LL_TABLE_ADDR_WIDTH since the task struct carries the pointer.
module ll_head_table_lookup
    import ll_head_table_pkg::*;
#(
    parameter int RAM_LATENCY = 2,
    parameter int A_WIDTH     = LL_TABLE_ADDR_WIDTH,
    parameter int QUEUE_CNT   = 16,
    parameter int Q_WIDTH     = $clog2(QUEUE_CNT)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  ll_ht_command_t       cmd_i,
    input  logic [Q_WIDTH-1:0]   cmd_queue_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    output ll_ht_pdata_t         task_o,
    output logic [Q_WIDTH-1:0]   task_queue_o,
    output logic                 task_valid_o,
    input  logic                 task_ready_i,
    input  logic                 op_done_i,
    input  logic [Q_WIDTH-1:0]   head_wr_queue_i,
    input  logic [A_WIDTH-1:0]   head_wr_ptr_i,
    input  logic                 head_wr_ptr_val_i,
    input  logic                 head_wr_en_i,
    output logic                 init_done_o
);

    localparam int CNT_W = $clog2(RAM_LATENCY + 1);

    typedef enum logic [2:0] {
        CLEAR_S,
        IDLE_S,
        READ_S,
        OUT_S,
        WAIT_DONE_S
    } state_e;

    typedef struct packed {
        logic [A_WIDTH-1:0] ptr;
        logic               val;
    } head_t;

    state_e             state_q, state_d;
    logic [Q_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    head_t              fwd_q, fwd_d;
    logic               fwd_vld_q, fwd_vld_d;
    ll_ht_pdata_t       task_q, task_d;
    logic [Q_WIDTH-1:0] task_queue_q, task_queue_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               task_valid_q, task_valid_d;
    logic               init_done_q, init_done_d;

    head_t              head_mem [QUEUE_CNT];
    head_t              rd_pipe_q [RAM_LATENCY];
    head_t              wr_entry;
    head_t              rd_head;
    logic               wr_hit;

    assign wr_entry = '{ptr: head_wr_ptr_i, val: head_wr_ptr_val_i};
    // task_queue_q doubles as the locked queue and the RAM read address.
    assign wr_hit   = head_wr_en_i && (head_wr_queue_i == task_queue_q);

    // NOTE: storage and read pipeline carry no reset; the clear sweep initialises the table.
    always_ff @(posedge clk_i) begin
        if (state_q == CLEAR_S) begin
            head_mem[clr_idx_q] <= '0;
        end else if (head_wr_en_i) begin
            head_mem[head_wr_queue_i] <= wr_entry;
        end
        rd_pipe_q[0] <= head_mem[task_queue_q];
        for (int i = 1; i < RAM_LATENCY; i++) begin
            rd_pipe_q[i] <= rd_pipe_q[i-1];
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        rd_cnt_d     = rd_cnt_q;
        fwd_d        = fwd_q;
        fwd_vld_d    = fwd_vld_q;
        task_d       = task_q;
        task_queue_d = task_queue_q;
        rd_head      = rd_pipe_q[RAM_LATENCY-1];

        case (state_q)
            CLEAR_S: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == Q_WIDTH'(QUEUE_CNT - 1)) begin
                    state_d = IDLE_S;
                end
            end
            IDLE_S: begin
                if (cmd_valid_i) begin
                    task_d.cmd   = cmd_i;
                    task_queue_d = cmd_queue_i;
                    rd_cnt_d     = '0;
                    fwd_d        = wr_entry;
                    fwd_vld_d    = head_wr_en_i && (head_wr_queue_i == cmd_queue_i);
                    state_d      = READ_S;
                end
            end
            READ_S: begin
                if (rd_cnt_q == CNT_W'(RAM_LATENCY)) begin
                    // Freshest wins: this edge's write, then a captured one, then RAM.
                    if (wr_hit) begin
                        rd_head = wr_entry;
                    end else if (fwd_vld_q) begin
                        rd_head = fwd_q;
                    end
                    task_d.head_ptr     = rd_head.ptr;
                    task_d.head_ptr_val = rd_head.val;
                    state_d             = OUT_S;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (wr_hit) begin
                        fwd_d     = wr_entry;
                        fwd_vld_d = 1'b1;
                    end
                end
            end
            OUT_S: begin
                if (task_ready_i) begin
                    state_d = WAIT_DONE_S;
                end
            end
            WAIT_DONE_S: begin
                if (op_done_i) begin
                    state_d = IDLE_S;
                end
            end
            default: state_d = CLEAR_S;
        endcase

        cmd_ready_d  = (state_d == IDLE_S);
        task_valid_d = (state_d == OUT_S);
        init_done_d  = (state_d != CLEAR_S);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= CLEAR_S;
            clr_idx_q    <= '0;
            rd_cnt_q     <= '0;
            fwd_q        <= '0;
            fwd_vld_q    <= 1'b0;
            task_q       <= '0;
            task_queue_q <= '0;
            cmd_ready_q  <= 1'b0;
            task_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            rd_cnt_q     <= rd_cnt_d;
            fwd_q        <= fwd_d;
            fwd_vld_q    <= fwd_vld_d;
            task_q       <= task_d;
            task_queue_q <= task_queue_d;
            cmd_ready_q  <= cmd_ready_d;
            task_valid_q <= task_valid_d;
            init_done_q  <= init_done_d;
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign task_o       = task_q;
    assign task_queue_o = task_queue_q;
    assign task_valid_o = task_valid_q;
    assign init_done_o  = init_done_q;

endmodule

// File: tb/tb_ll_head_table_lookup.sv
// Scoreboard bench for ll_head_table_lookup against an array model of the head table.
module tb_ll_head_table_lookup;
    import ll_head_table_pkg::*;

    localparam int L  = 2;
    localparam int QC = 16;
    localparam int QW = 4;
    localparam int AW = LL_TABLE_ADDR_WIDTH;

    logic           clk = 1'b0;
    logic           rst_n;
    ll_ht_command_t cmd_i;
    logic [QW-1:0]  cmd_queue_i;
    logic           cmd_valid_i;
    logic           cmd_ready_o;
    ll_ht_pdata_t   task_o;
    logic [QW-1:0]  task_queue_o;
    logic           task_valid_o;
    logic           task_ready_i;
    logic           op_done_i;
    logic [QW-1:0]  head_wr_queue_i;
    logic [AW-1:0]  head_wr_ptr_i;
    logic           head_wr_ptr_val_i;
    logic           head_wr_en_i;
    logic           init_done_o;

    always #5 clk = ~clk;

    ll_head_table_lookup #(.RAM_LATENCY(L), .A_WIDTH(AW), .QUEUE_CNT(QC)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .cmd_i            (cmd_i),
        .cmd_queue_i      (cmd_queue_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .task_o           (task_o),
        .task_queue_o     (task_queue_o),
        .task_valid_o     (task_valid_o),
        .task_ready_i     (task_ready_i),
        .op_done_i        (op_done_i),
        .head_wr_queue_i  (head_wr_queue_i),
        .head_wr_ptr_i    (head_wr_ptr_i),
        .head_wr_ptr_val_i(head_wr_ptr_val_i),
        .head_wr_en_i     (head_wr_en_i),
        .init_done_o      (init_done_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the table as the engine sees it, cleared on reset,
    // deaf to writes for the QC cycles of the sweep, last write wins after that.
    typedef struct packed {
        logic [AW-1:0] ptr;
        logic          val;
    } entry_t;

    entry_t model [QC];
    int     clr_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QC; i++) model[i] <= '0;
            clr_cnt <= 0;
        end else if (clr_cnt < QC) begin
            clr_cnt <= clr_cnt + 1;
        end else if (head_wr_en_i) begin
            model[head_wr_queue_i] <= '{ptr: head_wr_ptr_i, val: head_wr_ptr_val_i};
        end
    end

    typedef struct {
        ll_ht_pdata_t  t;
        logic [QW-1:0] q;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n && task_valid_o && task_ready_i) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_task", {44'd0, task_o}, 64'hDEAD);
            end else begin
                mon_e = sb.pop_front();
                check("task_data", {45'd0, task_o}, {45'd0, mon_e.t});
                check("task_queue", {60'd0, task_queue_o}, {60'd0, mon_e.q});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [QW-1:0] q, input logic [AW-1:0] p, input logic v);
        head_wr_en_i      = en;
        head_wr_queue_i   = q;
        head_wr_ptr_i     = p;
        head_wr_ptr_val_i = v;
    endtask

    task automatic write_head(input logic [QW-1:0] q, input logic [AW-1:0] p, input logic v);
        set_wr(1'b1, q, p, v);
        tick();
        set_wr(1'b0, '0, '0, 1'b0);
    endtask

    task automatic rand_wr(input logic [QW-1:0] q);
        logic [QW-1:0] wq;
        wq = $urandom_range(0, 1) ? q : QW'($urandom_range(0, QC - 1));
        set_wr(1'b1, wq, AW'($urandom), 1'($urandom));
    endtask

    function automatic ll_ht_command_t rand_cmd();
        ll_ht_command_t c;
        c.key    = 8'($urandom);
        c.opcode = ll_op_e'($urandom_range(0, 3));
        return c;
    endfunction

    // force_k: 0 = write in the issue cycle, 1..L+1 = write committed at edge T+k.
    task automatic lookup(input logic [QW-1:0] q, input ll_ht_command_t c, input int force_k,
                          input logic [AW-1:0] fptr, input logic fval, input bit rnd);
        int n = 0;
        cmd_i       = c;
        cmd_queue_i = q;
        cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", {63'd0, cmd_ready_o}, 64'd1);
        if (force_k == 0) set_wr(1'b1, q, fptr, fval);
        else if (rnd && $urandom_range(0, 3) == 0) rand_wr(q);
        tick();
        cmd_valid_i = 1'b0;
        for (int k = 1; k <= L + 1; k++) begin
            if (force_k == k) set_wr(1'b1, q, fptr, fval);
            else if (rnd && $urandom_range(0, 2) == 0) rand_wr(q);
            else set_wr(1'b0, '0, '0, 1'b0);
            @(negedge clk);
            if (k == L + 1) check("latency_pre", {63'd0, task_valid_o}, 64'd0);
            tick();
        end
        set_wr(1'b0, '0, '0, 1'b0);
        last_exp.t.cmd          = c;
        last_exp.t.head_ptr     = model[q].ptr;
        last_exp.t.head_ptr_val = model[q].val;
        last_exp.q              = q;
        sb.push_back(last_exp);
        @(negedge clk);
        check("latency", {63'd0, task_valid_o}, 64'd1);
    endtask

    task automatic complete(input int bp, input bit stray, input int idle,
                            input bit wr, input logic [QW-1:0] wq, input logic [AW-1:0] wp, input logic wv);
        task_ready_i = 1'b0;
        for (int i = 0; i < bp; i++) begin
            op_done_i = stray && (i == 0);
            @(negedge clk);
            check("bp_valid", {63'd0, task_valid_o}, 64'd1);
            check("bp_stable", {45'd0, task_o}, {45'd0, last_exp.t});
            tick();
        end
        op_done_i    = 1'b0;
        task_ready_i = 1'b1;
        @(negedge clk);
        tick();
        task_ready_i = 1'b0;
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            check("serial_hold", {62'd0, cmd_ready_o, task_valid_o}, 64'd0);
            tick();
        end
        op_done_i = 1'b1;
        if (wr) set_wr(1'b1, wq, wp, wv);
        tick();
        op_done_i = 1'b0;
        set_wr(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check("ready_after_done", {63'd0, cmd_ready_o}, 64'd1);
    endtask

    // Held cmd_valid must not be taken until the sweep ends; writes during it are dropped.
    task automatic sweep();
        cmd_i        = rand_cmd();
        cmd_queue_i  = 4'd5;
        cmd_valid_i  = 1'b1;
        task_ready_i = 1'b0;
        op_done_i    = 1'b0;
        set_wr(1'b1, 4'd5, 8'h77, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= QC; i++) begin
            @(negedge clk);
            if (i == QC - 1) set_wr(1'b0, '0, '0, 1'b0);
            check(i == QC ? "sweep_done" : "sweep_busy",
                  {62'd0, cmd_ready_o, init_done_o}, (i == QC) ? 64'd3 : 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cmd_i = '0;
        cmd_queue_i = '0;
        cmd_valid_i = 1'b0;
        task_ready_i = 1'b0;
        op_done_i = 1'b0;
        set_wr(1'b0, '0, '0, 1'b0);
        #12;
        check("rst_flags", {61'd0, cmd_ready_o, task_valid_o, init_done_o}, 64'd0);
        check("rst_task", {41'd0, task_queue_o, task_o}, 64'd0);

        sweep();
        lookup(4'd5, rand_cmd(), -1, '0, 1'b0, 1'b0);
        complete(0, 1'b0, 0, 1'b0, '0, '0, 1'b0);

        write_head(4'd3, 8'h2A, 1'b1);
        lookup(4'd3, rand_cmd(), -1, '0, 1'b0, 1'b0);
        complete(0, 1'b0, 2, 1'b0, '0, '0, 1'b0);

        write_head(4'd7, 8'h10, 1'b1);
        lookup(4'd7, rand_cmd(), 1, 8'h11, 1'b1, 1'b0);
        complete(0, 1'b0, 20, 1'b1, 4'd7, 8'h00, 1'b0);
        lookup(4'd7, rand_cmd(), -1, '0, 1'b0, 1'b0);
        complete(10, 1'b1, 3, 1'b0, '0, '0, 1'b0);

        write_head(4'd9, 8'h30, 1'b1);
        lookup(4'd9, rand_cmd(), 0, 8'h31, 1'b1, 1'b0);
        complete(0, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        lookup(4'd9, rand_cmd(), L + 1, 8'h32, 1'b1, 1'b0);
        complete(1, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        lookup(4'd9, rand_cmd(), L, 8'h33, 1'b0, 1'b0);
        complete(0, 1'b0, 0, 1'b0, '0, '0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            logic [QW-1:0] q;
            q = QW'($urandom_range(0, QC - 1));
            for (int j = $urandom_range(0, 3); j > 0; j--) begin
                rand_wr(q);
                tick();
            end
            set_wr(1'b0, '0, '0, 1'b0);
            lookup(q, rand_cmd(), -1, '0, 1'b0, 1'b1);
            complete($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                     1'($urandom), q, AW'($urandom), 1'($urandom));
        end

        cmd_i       = rand_cmd();
        cmd_queue_i = 4'd3;
        cmd_valid_i = 1'b1;
        @(negedge clk);
        tick();
        cmd_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_flags", {61'd0, cmd_ready_o, task_valid_o, init_done_o}, 64'd0);
        sweep();
        for (int q = 0; q < QC; q++) begin
            lookup(QW'(q), rand_cmd(), -1, '0, 1'b0, 1'b0);
            complete(0, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
